simd_sat_addsub_pipe: RTL and testbench

SIMD_SAT_ADDSUB_PIPE -- requirements
Module: simd_sat_addsub_pipe

---
 rtl/simd_sat_addsub_pipe.sv | 138 +++++++++++++
 tb/tb_simd_sat_addsub_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/simd_sat_addsub_pipe.sv
// Two-stage lane-parallel signed add/sub with saturate or wrap modes.
// Ports: clk, rst_n (async low); in_valid/in_ready carry a, b, op
// into S1; out_valid/out_ready carry result and lane_ovf out of S2;
// ovf_sticky accumulates lane_ovf on delivery; ovf_clr clears it.
module simd_sat_addsub_pipe #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANE_W*LANES-1:0]  a,
    input  logic [LANE_W*LANES-1:0]  b,
    input  logic [1:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W*LANES-1:0]  result,
    output logic [LANES-1:0]         lane_ovf,
    output logic [LANES-1:0]         ovf_sticky,
    input  logic                     ovf_clr
);

    localparam int W   = LANE_W * LANES;
    localparam int MSB = LANE_W - 1;

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     result_q, result_d;
    logic [LANES-1:0] ovf_q, ovf_d;
    logic [LANES-1:0] sticky_q, sticky_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             out_hs;
    logic [W-1:0]     lane_res;
    logic [LANES-1:0] lane_ov;

    assign s2_adv = ~s2_valid_q | out_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;
    assign out_hs = s2_valid_q & out_ready;

    // op_q[0] selects subtract, op_q[1] selects wrap instead of saturate.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W-1:0] bx;
        logic [LANE_W-1:0] raw;
        logic [LANE_W-1:0] sat;
        logic              same_sign;
        logic              flip;
        logic              ov;

        assign la  = a_q[k*LANE_W +: LANE_W];
        assign lb  = b_q[k*LANE_W +: LANE_W];
        assign bx  = op_q[0] ? ~lb : lb;
        assign raw = la + bx + {{(LANE_W-1){1'b0}}, op_q[0]};

        assign same_sign = (la[MSB] == lb[MSB]);
        assign flip      = (raw[MSB] != la[MSB]);
        assign ov        = (op_q[0] ? ~same_sign : same_sign) & flip;

        // Clamp toward the sign of A: max positive or min negative.
        assign sat = la[MSB] ? {1'b1, {(LANE_W-1){1'b0}}}
                             : {1'b0, {(LANE_W-1){1'b1}}};

        assign lane_res[k*LANE_W +: LANE_W] = (ov & ~op_q[1]) ? sat : raw;
        assign lane_ov[k] = ov;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        sticky_d   = sticky_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d  = a;
                b_d  = b;
                op_d = op;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = lane_res;
                ovf_d    = lane_ov;
            end
        end

        // A delivery in the same cycle as a clear survives the clear.
        if (ovf_clr) begin
            sticky_d = out_hs ? ovf_q : '0;
        end else if (out_hs) begin
            sticky_d = sticky_q | ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= '0;
            sticky_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            sticky_q   <= sticky_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign result     = result_q;
    assign lane_ovf   = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_simd_sat_addsub_pipe.sv
// Directed bench for simd_sat_addsub_pipe at LANE_W=4, LANES=4.
// Hand-computed vectors cover modes, backpressure, clear and reset.
module tb_simd_sat_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  lane_ovf;
    logic [3:0]  ovf_sticky;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    simd_sat_addsub_pipe #(
        .LANE_W(4),
        .LANES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lane_ovf  (lane_ovf),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // One beat with out_ready high; ends on a negedge after delivery.
    task automatic send(input string tag,
                        input logic [15:0] ta,
                        input logic [15:0] tb,
                        input logic [1:0]  top,
                        input logic [15:0] eres,
                        input logic [3:0]  eovf);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        op        = top;
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'hFFFF;
        op       = ~top;
        #1 chk({tag, "_lat"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, result, eres);
        chk({tag, "_ovf"}, lane_ovf, eovf);
        @(posedge clk);
        @(negedge clk);
        #1 chk({tag, "_drain"}, out_valid, 0);
    endtask

    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic [1:0]  vo[4];
    logic [15:0] vr[4];
    logic [3:0]  vf[4];

    initial begin
        int acc;
        int del;
        bit hs_in;
        bit hs_out;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;

        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", lane_ovf, 0);
        chk("rst_sticky", ovf_sticky, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        send("add_sat", 16'h7381, 16'h11F1, 2'b00, 16'h7482, 4'b1010);
        chk("sticky_1", ovf_sticky, 4'b1010);
        send("sub_sat", 16'h8075, 16'h18F2, 2'b01, 16'h8773, 4'b1110);
        chk("sticky_2", ovf_sticky, 4'b1110);
        send("add_wrap", 16'h7381, 16'h11F1, 2'b10, 16'h8472, 4'b1010);
        send("sub_wrap", 16'h8075, 16'h18F2, 2'b11, 16'h7883, 4'b1110);
        chk("sticky_3", ovf_sticky, 4'b1110);

        va[0] = 16'h1111; vb[0] = 16'h2222; vo[0] = 2'b00;
        vr[0] = 16'h3333; vf[0] = 4'b0000;
        va[1] = 16'h7381; vb[1] = 16'h11F1; vo[1] = 2'b00;
        vr[1] = 16'h7482; vf[1] = 4'b1010;
        va[2] = 16'h8075; vb[2] = 16'h18F2; vo[2] = 2'b01;
        vr[2] = 16'h8773; vf[2] = 4'b1110;
        va[3] = 16'h1234; vb[3] = 16'h1111; vo[3] = 2'b01;
        vr[3] = 16'h0123; vf[3] = 4'b0000;

        acc = 0;
        del = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 1 && c <= 3);
            if (acc < 4) begin
                in_valid = 1'b1;
                a        = va[acc];
                b        = vb[acc];
                op       = vo[acc];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2 || c == 3) chk("bp_in_ready", in_ready, 0);
            if (out_valid) begin
                if (del < 4) begin
                    chk("bp_res", result, vr[del]);
                    chk("bp_ovf", lane_ovf, vf[del]);
                end else begin
                    chk("bp_extra", out_valid, 0);
                end
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            @(posedge clk);
            if (hs_in) acc++;
            if (hs_out) del++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 4);
        chk("bp_delivered", del, 4);
        #1 chk("bp_sticky", ovf_sticky, 4'b1110);

        @(negedge clk);
        in_valid  = 1'b1;
        a         = 16'h0007;
        b         = 16'h0001;
        op        = 2'b00;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("clr_valid", out_valid, 1);
        chk("clr_res", result, 16'h0007);
        chk("clr_ovf", lane_ovf, 4'b0001);
        chk("clr_pre_sticky", ovf_sticky, 4'b1110);
        ovf_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovf_clr = 1'b0;
        #1 chk("clr_hs_sticky", ovf_sticky, 4'b0001);

        in_valid  = 1'b1;
        a         = 16'h7381;
        b         = 16'h11F1;
        op        = 2'b00;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 chk("rst_stall_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_sticky", ovf_sticky, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rel_in_ready", in_ready, 1);
        send("after_rst", 16'h1234, 16'h1111, 2'b01, 16'h0123, 4'b0000);
        chk("after_rst_sticky", ovf_sticky, 0);

        send("refill", 16'h7381, 16'h11F1, 2'b00, 16'h7482, 4'b1010);
        chk("refill_sticky", ovf_sticky, 4'b1010);
        ovf_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovf_clr = 1'b0;
        #1 chk("clr_only_sticky", ovf_sticky, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
